l1_line_arbiter: RTL and testbench

//  Shares the single L1-to-memory port between NUM_REQ cache requesters (icache/dcache of both cores).

---
 rtl/l1_line_arbiter_pkg.sv | 13 +
 rtl/l1_line_arbiter_checker.sv | 27 ++
 rtl/l1_line_arbiter_picker.sv | 32 +++
 rtl/l1_line_arbiter.sv | 151 +++++++++++++++
 tb/tb_l1_line_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_line_arbiter_pkg.sv
// Shared types for the L1-to-memory line arbiter.
package l1_line_arbiter_pkg;

    // Number of L1 caches sharing the memory port (icache/dcache of two cores).
    localparam int L1_CONNECTIONS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2
    } l1_arb_state_t;

endpackage

// File: rtl/l1_line_arbiter_checker.sv
// Protocol checks for the L1 line arbiter.
module l1_line_arbiter_checker #(
    parameter int NUM_REQ = 4
) (
    input logic               clk,
    input logic               rst,
    input logic [NUM_REQ-1:0] ack,
    input logic [NUM_REQ-1:0] pick_grant,
    input logic               mem_request,
    input logic               mem_ack,
    input logic               mem_data_valid,
    input logic               in_burst
);

    a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ack))
        else $error("ack is not one-hot");

    a_pick_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(pick_grant))
        else $error("picker grant is not one-hot");

    a_ack_needs_req: assert property (@(posedge clk) disable iff (rst) mem_ack |-> mem_request)
        else $error("mem_ack without mem_request");

    a_beat_in_burst: assert property (@(posedge clk) disable iff (rst) mem_data_valid |-> in_burst)
        else $error("mem_data_valid outside BURST");

endmodule

// File: rtl/l1_line_arbiter_picker.sv
// Round-robin priority picker: first set request at or after the pointer.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               valid
);

    int   idx_s;
    logic hit_s;

    // Scan requesters starting at the pointer, wrapping once around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        idx_s     = 0;
        hit_s     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s        = (int'(ptr) + i) % NUM_REQ;
            hit_s        = ~valid & req[idx_s];
            grant[idx_s] = hit_s;
            grant_idx    = hit_s ? PTR_W'(idx_s) : grant_idx;
            valid        = valid | hit_s;
        end
    end

endmodule

// File: rtl/l1_line_arbiter.sv
// Arbitrates the single L1-to-memory port between NUM_REQ cache requesters,
// forwarding one transaction at a time and routing read beats to the owner.
module l1_line_arbiter
    import l1_line_arbiter_pkg::*;
#(
    parameter int NUM_REQ = L1_CONNECTIONS,
    parameter int SIZE_W  = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0][31:0]        req_addr,
    input  logic [NUM_REQ-1:0]              req_rnw,
    input  logic [NUM_REQ-1:0][SIZE_W-1:0]  req_size,
    input  logic [NUM_REQ-1:0][31:0]        req_data,
    input  logic [NUM_REQ-1:0][3:0]         req_be,
    output logic [NUM_REQ-1:0]              ack,
    output logic                            mem_request,
    output logic [31:0]                     mem_addr,
    output logic                            mem_rnw,
    output logic [SIZE_W-1:0]               mem_size,
    output logic [31:0]                     mem_data,
    output logic [3:0]                      mem_be,
    input  logic                            mem_ack,
    input  logic                            mem_data_valid,
    input  logic [31:0]                     mem_data_in,
    output logic [NUM_REQ-1:0]              resp_data_valid,
    output logic [31:0]                     resp_data,
    output logic                            busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    l1_arb_state_t     state_r, next_state_s;
    logic [PTR_W-1:0]  owner_r, next_owner_s;
    logic [PTR_W-1:0]  rr_ptr_r, next_ptr_s;
    logic [SIZE_W-1:0] beat_cnt_r, next_cnt_s;
    logic [SIZE_W-1:0] size_r, next_size_s;

    logic [NUM_REQ-1:0] pick_grant_s;
    logic [PTR_W-1:0]   pick_idx_s;
    logic               pick_valid_s;

    rr_priority_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
        .req       (req),
        .ptr       (rr_ptr_r),
        .grant     (pick_grant_s),
        .grant_idx (pick_idx_s),
        .valid     (pick_valid_s)
    );

    // Next-state, owner bookkeeping and owner-muxed memory/response outputs.
    always_comb begin
        next_state_s    = state_r;
        next_owner_s    = owner_r;
        next_ptr_s      = rr_ptr_r;
        next_cnt_s      = beat_cnt_r;
        next_size_s     = size_r;
        ack             = '0;
        resp_data_valid = '0;
        mem_request     = 1'b0;
        mem_addr        = 32'h0000_0000;
        mem_rnw         = 1'b0;
        mem_size        = '0;
        mem_data        = 32'h0000_0000;
        mem_be          = 4'h0;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    next_owner_s = pick_idx_s;
                    next_state_s = GRANT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GRANT: begin
                mem_request = req[owner_r];
                mem_addr    = req_addr[owner_r];
                mem_rnw     = req_rnw[owner_r];
                mem_size    = req_size[owner_r];
                mem_data    = req_data[owner_r];
                mem_be      = req_be[owner_r];
                if (!req[owner_r]) begin
                    // Requester withdrew before acceptance; pointer stays put.
                    next_state_s = IDLE;
                end else if (mem_ack) begin
                    ack[owner_r] = 1'b1;
                    next_ptr_s   = (owner_r == PTR_W'(NUM_REQ - 1)) ? '0 : owner_r + PTR_W'(1);
                    if (req_rnw[owner_r]) begin
                        next_size_s  = req_size[owner_r];
                        next_cnt_s   = '0;
                        next_state_s = BURST;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = GRANT;
                end
            end
            BURST: begin
                resp_data_valid[owner_r] = mem_data_valid;
                if (mem_data_valid) begin
                    if (beat_cnt_r == size_r) begin
                        // Final beat: leave before the counter could wrap.
                        next_cnt_s   = '0;
                        next_state_s = IDLE;
                    end else begin
                        next_cnt_s = beat_cnt_r + SIZE_W'(1);
                    end
                end else begin
                    next_cnt_s = beat_cnt_r;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, owner, round-robin pointer and beat tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            owner_r    <= '0;
            rr_ptr_r   <= '0;
            beat_cnt_r <= '0;
            size_r     <= '0;
        end else begin
            state_r    <= next_state_s;
            owner_r    <= next_owner_s;
            rr_ptr_r   <= next_ptr_s;
            beat_cnt_r <= next_cnt_s;
            size_r     <= next_size_s;
        end
    end

    assign resp_data = mem_data_in;
    assign busy      = (state_r != IDLE);

    l1_line_arbiter_checker #(.NUM_REQ(NUM_REQ)) u_checker (
        .clk            (clk),
        .rst            (rst),
        .ack            (ack),
        .pick_grant     (pick_grant_s),
        .mem_request    (mem_request),
        .mem_ack        (mem_ack),
        .mem_data_valid (mem_data_valid),
        .in_burst       (state_r == BURST)
    );

endmodule

// File: tb/tb_l1_line_arbiter.sv
// Directed-vector bench for l1_line_arbiter.
module tb_l1_line_arbiter;

    logic             clk;
    logic             rst;
    logic [3:0]       req;
    logic [3:0][31:0] req_addr;
    logic [3:0]       req_rnw;
    logic [3:0][4:0]  req_size;
    logic [3:0][31:0] req_data;
    logic [3:0][3:0]  req_be;
    logic [3:0]       ack;
    logic             mem_request;
    logic [31:0]      mem_addr;
    logic             mem_rnw;
    logic [4:0]       mem_size;
    logic [31:0]      mem_data;
    logic [3:0]       mem_be;
    logic             mem_ack;
    logic             mem_data_valid;
    logic [31:0]      mem_rdata;
    logic [3:0]       resp_data_valid;
    logic [31:0]      resp_data;
    logic             busy;

    int vec_cnt;
    int err_cnt;

    l1_line_arbiter #(.NUM_REQ(4), .SIZE_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_addr        (req_addr),
        .req_rnw         (req_rnw),
        .req_size        (req_size),
        .req_data        (req_data),
        .req_be          (req_be),
        .ack             (ack),
        .mem_request     (mem_request),
        .mem_addr        (mem_addr),
        .mem_rnw         (mem_rnw),
        .mem_size        (mem_size),
        .mem_data        (mem_data),
        .mem_be          (mem_be),
        .mem_ack         (mem_ack),
        .mem_data_valid  (mem_data_valid),
        .mem_data_in     (mem_rdata),
        .resp_data_valid (resp_data_valid),
        .resp_data       (resp_data),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full read burst from requester r, mem_ack in the first GRANT cycle.
    task automatic do_read(input int r, input logic [4:0] sz);
        int   beats;
        logic [3:0] exp_oh;
        beats  = 0;
        exp_oh = 4'b0001 << r;
        req         = 4'b0000;
        req[r]      = 1'b1;
        req_rnw[r]  = 1'b1;
        req_size[r] = sz;
        req_addr[r] = 32'h4000_0000 + 32'(r);
        step();
        mem_ack = 1'b1;
        #1;
        chk_eq("rd_mem_request", 64'(mem_request), 64'd1);
        chk_eq("rd_mem_size", 64'(mem_size), 64'(sz));
        chk_eq("rd_ack", 64'(ack), 64'(exp_oh));
        step();
        mem_ack = 1'b0;
        req     = 4'b0000;
        for (int i = 0; i <= int'(sz); i++) begin
            mem_data_valid = 1'b1;
            mem_rdata      = 32'hB000_0000 + 32'(i);
            #1;
            if (resp_data_valid == exp_oh && resp_data == mem_rdata) beats++;
            step();
        end
        mem_data_valid = 1'b0;
        #1;
        chk_eq("rd_busy_after", 64'(busy), 64'd0);
        chk_eq("rd_beats", 64'(beats), 64'(int'(sz) + 1));
    endtask

    int   exp_order [5];
    int   beats_seen;

    initial begin
        vec_cnt        = 0;
        err_cnt        = 0;
        rst            = 1'b1;
        req            = '0;
        req_addr       = '0;
        req_rnw        = '0;
        req_size       = '0;
        req_data       = '0;
        req_be         = '0;
        mem_ack        = 1'b0;
        mem_data_valid = 1'b0;
        mem_rdata      = 32'h0000_0000;
        exp_order      = '{0, 1, 2, 3, 0};

        // Reset state
        step();
        step();
        chk_eq("rst_busy", 64'(busy), 64'd0);
        chk_eq("rst_ack", 64'(ack), 64'd0);
        chk_eq("rst_mem_request", 64'(mem_request), 64'd0);
        chk_eq("rst_rdv", 64'(resp_data_valid), 64'd0);
        rst = 1'b0;
        step();

        // Single read, requester 0, size 7, mem_ack two cycles after req
        req[0]      = 1'b1;
        req_rnw[0]  = 1'b1;
        req_size[0] = 5'd7;
        req_addr[0] = 32'h0000_1000;
        #1;
        chk_eq("sr_latency", 64'(mem_request), 64'd0);
        step();
        chk_eq("sr_grant_req", 64'(mem_request), 64'd1);
        chk_eq("sr_addr", 64'(mem_addr), 64'h0000_1000);
        chk_eq("sr_rnw", 64'(mem_rnw), 64'd1);
        chk_eq("sr_busy", 64'(busy), 64'd1);
        chk_eq("sr_no_ack_yet", 64'(ack), 64'd0);
        step();
        mem_ack = 1'b1;
        #1;
        chk_eq("sr_ack", 64'(ack), 64'b0001);
        step();
        mem_ack    = 1'b0;
        req        = 4'b0000;
        beats_seen = 0;
        for (int i = 0; i < 8; i++) begin
            mem_data_valid = 1'b1;
            mem_rdata      = 32'hA000_0000 + 32'(i);
            #1;
            chk_eq("sr_ack_quiet", 64'(ack), 64'd0);
            if (resp_data_valid == 4'b0001 && busy) beats_seen++;
            step();
        end
        mem_data_valid = 1'b0;
        #1;
        chk_eq("sr_beats", 64'(beats_seen), 64'd8);
        chk_eq("sr_busy_drop", 64'(busy), 64'd0);

        // Write from requester 1
        req[1]      = 1'b1;
        req_rnw[1]  = 1'b0;
        req_addr[1] = 32'h0000_2004;
        req_data[1] = 32'hDEAD_BEEF;
        req_be[1]   = 4'hF;
        step();
        mem_ack = 1'b1;
        #1;
        chk_eq("wr_addr", 64'(mem_addr), 64'h0000_2004);
        chk_eq("wr_rnw", 64'(mem_rnw), 64'd0);
        chk_eq("wr_data", 64'(mem_data), 64'hDEAD_BEEF);
        chk_eq("wr_be", 64'(mem_be), 64'hF);
        chk_eq("wr_ack", 64'(ack), 64'b0010);
        step();
        mem_ack = 1'b0;
        req     = 4'b0000;
        #1;
        chk_eq("wr_idle", 64'(busy), 64'd0);
        chk_eq("wr_no_beats", 64'(resp_data_valid), 64'd0);

        // Abort: requester 2 drops in GRANT, requester 3 served next
        req_rnw[2] = 1'b0;
        req_rnw[3] = 1'b0;
        req        = 4'b1100;
        step();
        chk_eq("ab_grant_req", 64'(mem_request), 64'd1);
        chk_eq("ab_grant_addr", 64'(mem_addr), 64'(req_addr[2]));
        req = 4'b1000;
        #1;
        chk_eq("ab_drop_req", 64'(mem_request), 64'd0);
        chk_eq("ab_no_ack", 64'(ack), 64'd0);
        step();
        chk_eq("ab_idle", 64'(busy), 64'd0);
        chk_eq("ab_idle_req", 64'(mem_request), 64'd0);
        step();
        mem_ack = 1'b1;
        #1;
        chk_eq("ab_next_ack", 64'(ack), 64'b1000);
        step();
        mem_ack = 1'b0;
        req     = 4'b0000;

        // Abort of requester 0 must leave the pointer at 0
        req_rnw[0] = 1'b0;
        req_rnw[1] = 1'b0;
        req        = 4'b0011;
        step();
        req = 4'b0010;
        step();
        req = 4'b0011;
        step();
        mem_ack = 1'b1;
        #1;
        chk_eq("ab2_ptr_kept", 64'(ack), 64'b0001);
        step();
        mem_ack = 1'b0;
        req     = 4'b0000;

        // Maximum burst, requester 3, 32 beats
        do_read(3, 5'd31);

        // Contention: all four writing, round-robin order 0,1,2,3,0
        req_rnw = 4'b0000;
        req     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk_eq("ct_idle_gap", 64'(busy), 64'd0);
            step();
            mem_ack = 1'b1;
            #1;
            chk_eq("ct_order", 64'(ack), 64'(4'b0001 << exp_order[k]));
            step();
            mem_ack = 1'b0;
        end
        req = 4'b0000;
        step();

        // Reset during beat 3 of 8 from requester 2
        req[2]      = 1'b1;
        req_rnw[2]  = 1'b1;
        req_size[2] = 5'd7;
        step();
        mem_ack = 1'b1;
        step();
        mem_ack    = 1'b0;
        req        = 4'b0000;
        beats_seen = 0;
        for (int i = 0; i < 8; i++) begin
            mem_data_valid = 1'b1;
            mem_rdata      = 32'hC000_0000 + 32'(i);
            if (i == 2) rst = 1'b1;
            #1;
            if (resp_data_valid != 4'b0000) beats_seen++;
            if (i == 3) chk_eq("rs_busy_next", 64'(busy), 64'd0);
            step();
        end
        mem_data_valid = 1'b0;
        rst            = 1'b0;
        #1;
        chk_eq("rs_beats", 64'(beats_seen), 64'd3);
        chk_eq("rs_busy", 64'(busy), 64'd0);

        // Pointer returned to 0 by reset
        req_rnw = 4'b0000;
        req     = 4'b1111;
        step();
        mem_ack = 1'b1;
        #1;
        chk_eq("rs_ptr_zero", 64'(ack), 64'b0001);
        step();
        mem_ack = 1'b0;
        req     = 4'b0000;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
